// File: rtl/vga_linefetch_if.sv
// Memory read port between the line fetcher (master) and the framebuffer (slave).
// rd_addr is held stable while rd_req=1 and rd_ack=0.
interface vga_linefetch_if #(
  parameter int AW = 17
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [11:0]   rd_data;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/vga_linefetch.sv
// Double-buffered line store feeding the 640x480 timing generator from a 320x240 framebuffer.
// Each stored pixel is shown for two advance cycles; each row is shown on two scanlines.
//
// state | meaning
// IDLE  | no fetch in progress; waiting for a newline whose next row needs fetching
// FETCH | requesting words of row tgt into bank tgt[0]
module vga_linefetch #(
  parameter int HPIX  = 320,
  parameter int VROWS = 240,
  parameter int AW    = 17,
  parameter int BASE  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 newline,
  input  logic                 advance,
  input  logic [7:0]           line,
  output logic [11:0]          pixel,
  output logic                 underrun,
  vga_linefetch_if.master      mem
);
  localparam int WW = $clog2(HPIX);
  localparam int PW = $clog2(2 * HPIX);
  localparam logic [WW-1:0] WORD_LAST = WW'(HPIX - 1);
  localparam logic [PW-1:0] PX_LAST   = PW'(2 * HPIX - 1);
  localparam logic [8:0]    VROWS9    = 9'(VROWS);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t        state;
  logic [7:0]    tgt;
  logic [WW-1:0] word;
  logic [7:0]    fetched_row;
  logic          fetched_vld;

  logic [PW-1:0] px;
  logic          sel;
  logic          blank;

  logic [11:0]   bank [2][HPIX];

  logic [7:0]    t_next;
  logic          line_vis;
  logic          start_ok;
  logic [AW-1:0] start_addr;
  logic [PW-1:0] px_step;
  logic [WW-1:0] rd_idx;

  always_comb begin
    t_next     = line + 8'd1;
    line_vis   = ({1'b0, line} < VROWS9);
    start_ok   = ({1'b0, t_next} < VROWS9) && !(fetched_vld && (t_next == fetched_row));
    start_addr = AW'(BASE) + AW'(t_next) * AW'(HPIX);
    px_step    = (px == PX_LAST) ? px : px + PW'(1);
    rd_idx     = WW'(px_step >> 1);
  end

  // Bank contents are deliberately not reset; only rows fetched since reset are meaningful.
  always_ff @(posedge clk) begin
    if (!reset && (state == FETCH) && mem.rd_ack)
      bank[tgt[0]][word] <= mem.rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tgt         <= '0;
      word        <= '0;
      fetched_row <= '0;
      fetched_vld <= 1'b0;
      mem.rd_req  <= 1'b0;
      mem.rd_addr <= '0;
      underrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (newline && start_ok) begin
            state       <= FETCH;
            tgt         <= t_next;
            word        <= '0;
            mem.rd_addr <= start_addr;
            mem.rd_req  <= 1'b1;
          end
        end
        FETCH: begin
          if (mem.rd_ack) begin
            word        <= word + WW'(1);
            mem.rd_addr <= mem.rd_addr + AW'(1);
          end
          // A final ack in the deadline cycle still completes the row cleanly.
          if (mem.rd_ack && (word == WORD_LAST)) begin
            mem.rd_req  <= 1'b0;
            fetched_row <= tgt;
            fetched_vld <= 1'b1;
            state       <= IDLE;
          end else if (newline && (line == tgt)) begin
            underrun    <= 1'b1;
            mem.rd_req  <= 1'b0;
            fetched_row <= tgt;
            fetched_vld <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      px    <= '0;
      sel   <= 1'b0;
      blank <= 1'b1;
      pixel <= '0;
    end else if (newline) begin
      px    <= '0;
      sel   <= line[0];
      blank <= !line_vis;
      pixel <= line_vis ? bank[line[0]][0] : 12'd0;
    end else if (advance) begin
      px    <= px_step;
      pixel <= blank ? 12'd0 : bank[sel][rd_idx];
    end
  end
endmodule

// File: tb/tb_vga_linefetch.sv
// Directed bench for vga_linefetch: a responding memory returns addr[11:0] as data,
// and each scenario task checks addresses, handshake and displayed pixels inline.
module tb_vga_linefetch;
  logic       clk = 1'b0;
  logic       reset;
  logic       newline;
  logic       advance;
  logic [7:0] line;
  logic [11:0] pixel;
  logic       underrun;

  int errors = 0;
  int checks = 0;

  int ack_div = 1;
  int ack_cnt = 0;
  int stall   = 0;
  int log_addr[$];

  vga_linefetch_if #(.AW(17)) mif ();

  vga_linefetch #(.HPIX(320), .VROWS(240), .AW(17), .BASE(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .newline  (newline),
    .advance  (advance),
    .line     (line),
    .pixel    (pixel),
    .underrun (underrun),
    .mem      (mif)
  );

  always #5 clk = ~clk;

  // Memory responder: logs accepted addresses, then sets up the next ack after the edge.
  always @(posedge clk) begin
    if (!reset && mif.rd_req && mif.rd_ack)
      log_addr.push_back(int'(mif.rd_addr));
    #1;
    if (mif.rd_req && !reset) begin
      if (stall > 0) begin
        mif.rd_ack = 1'b0;
        stall--;
      end else if (ack_div == 0) begin
        mif.rd_ack = 1'b0;
      end else begin
        ack_cnt++;
        mif.rd_ack = ((ack_cnt % ack_div) == 0);
      end
    end else begin
      mif.rd_ack = 1'b0;
    end
    mif.rd_data = mif.rd_addr[11:0];
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic newline_pulse(input logic [7:0] l);
    newline = 1'b1;
    line    = l;
    @(negedge clk);
    newline = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (mif.rd_req && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mif.rd_req !== 1'b0) begin
      errors++;
      $display("FAIL %s: rd_req still %b after %0d cycles, required 0", name, mif.rd_req, n);
    end
  endtask

  task automatic wait_acks(input int cnt);
    int n = 0;
    while (log_addr.size() < cnt && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (log_addr.size() != cnt) begin
      errors++;
      $display("FAIL wait_acks: ack count %0d, required %0d", log_addr.size(), cnt);
    end
  endtask

  task automatic show_row(input string name, input int base);
    logic [11:0] exp;
    for (int k = 0; k < 642; k++) begin
      advance = 1'b1;
      exp = (k < 640) ? 12'(base + k / 2) : 12'(base + 319);
      checks++;
      if (pixel !== exp) begin
        errors++;
        $display("FAIL %s px%0d: pixel %0d, required %0d", name, k, pixel, exp);
      end
      @(negedge clk);
    end
    advance = 1'b0;
  endtask

  task automatic check_log(input string name, input int base);
    checks++;
    if (log_addr.size() != 320) begin
      errors++;
      $display("FAIL %s count: %0d acks, required 320", name, log_addr.size());
    end else begin
      for (int i = 0; i < 320; i++) begin
        checks++;
        if (log_addr[i] != base + i) begin
          errors++;
          $display("FAIL %s addr[%0d]: %0d, required %0d", name, i, log_addr[i], base + i);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (pixel !== 12'd0) begin errors++; $display("FAIL reset pixel: %0d, required 0", pixel); end
    if (mif.rd_req !== 1'b0) begin errors++; $display("FAIL reset rd_req: %b, required 0", mif.rd_req); end
    if (mif.rd_addr !== 17'd0) begin errors++; $display("FAIL reset rd_addr: %0d, required 0", mif.rd_addr); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset underrun: %b, required 0", underrun); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (mif.rd_req !== 1'b0) begin errors++; $display("FAIL idle rd_req: %b, required 0", mif.rd_req); end
  endtask

  task automatic test_prefetch();
    log_addr.delete();
    ack_div = 1;
    newline_pulse(8'd255);
    checks += 2;
    if (mif.rd_req !== 1'b1) begin errors++; $display("FAIL prefetch start rd_req: %b, required 1", mif.rd_req); end
    if (mif.rd_addr !== 17'd0) begin errors++; $display("FAIL prefetch start addr: %0d, required 0", mif.rd_addr); end
    wait_idle("prefetch");
    check_log("prefetch", 0);
    repeat (10) @(negedge clk);
    checks++;
    if (mif.rd_req !== 1'b0) begin errors++; $display("FAIL prefetch no-restart rd_req: %b, required 0", mif.rd_req); end
    newline_pulse(8'd0);
    show_row("row0", 0);
    wait_idle("row1 fetch");
  endtask

  task automatic test_addressing();
    log_addr.delete();
    newline_pulse(8'd4);
    checks++;
    if (mif.rd_addr !== 17'd1600) begin errors++; $display("FAIL row5 first addr: %0d, required 1600", mif.rd_addr); end
    wait_idle("row5 fetch");
    check_log("row5", 1600);
    newline_pulse(8'd5);
    show_row("row5", 1600);
    wait_idle("row6 fetch");
  endtask

  task automatic test_stall();
    log_addr.delete();
    newline_pulse(8'd6);
    wait_acks(100);
    stall = 10;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks += 2;
      if (mif.rd_addr !== 17'd2341) begin errors++; $display("FAIL stall addr cyc%0d: %0d, required 2341", i, mif.rd_addr); end
      if (mif.rd_req !== 1'b1) begin errors++; $display("FAIL stall rd_req cyc%0d: %b, required 1", i, mif.rd_req); end
      @(negedge clk);
    end
    wait_idle("stall fetch");
    check_log("row7", 2240);
    newline_pulse(8'd7);
    show_row("row7", 2240);
    wait_idle("row8 fetch");
  endtask

  task automatic test_underrun();
    ack_div = 8;
    ack_cnt = 0;
    newline_pulse(8'd9);
    checks += 2;
    if (mif.rd_req !== 1'b1) begin errors++; $display("FAIL row10 start rd_req: %b, required 1", mif.rd_req); end
    if (mif.rd_addr !== 17'd3200) begin errors++; $display("FAIL row10 start addr: %0d, required 3200", mif.rd_addr); end
    repeat (50) @(negedge clk);
    newline_pulse(8'd9);
    checks += 2;
    if (mif.rd_req !== 1'b1) begin errors++; $display("FAIL second line9 rd_req: %b, required 1", mif.rd_req); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL second line9 underrun: %b, required 0", underrun); end
    repeat (50) @(negedge clk);
    newline_pulse(8'd10);
    checks += 2;
    if (underrun !== 1'b1) begin errors++; $display("FAIL deadline underrun: %b, required 1", underrun); end
    if (mif.rd_req !== 1'b0) begin errors++; $display("FAIL deadline rd_req: %b, required 0", mif.rd_req); end
    repeat (20) @(negedge clk);
    checks += 2;
    if (underrun !== 1'b1) begin errors++; $display("FAIL sticky underrun: %b, required 1", underrun); end
    if (mif.rd_req !== 1'b0) begin errors++; $display("FAIL no-retry rd_req: %b, required 0", mif.rd_req); end
    newline_pulse(8'd10);
    checks += 2;
    if (mif.rd_req !== 1'b1) begin errors++; $display("FAIL row11 start rd_req: %b, required 1", mif.rd_req); end
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun after new fetch: %b, required 1", underrun); end
  endtask

  task automatic test_blanking_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ack_div = 1;
    checks += 2;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun after reset: %b, required 0", underrun); end
    if (mif.rd_req !== 1'b0) begin errors++; $display("FAIL rd_req after reset: %b, required 0", mif.rd_req); end
    newline_pulse(8'd240);
    checks++;
    if (mif.rd_req !== 1'b0) begin errors++; $display("FAIL blank line240 rd_req: %b, required 0", mif.rd_req); end
    for (int k = 0; k < 20; k++) begin
      advance = 1'b1;
      checks++;
      if (pixel !== 12'd0) begin errors++; $display("FAIL blank pixel px%0d: %0d, required 0", k, pixel); end
      @(negedge clk);
    end
    advance = 1'b0;
    newline_pulse(8'd239);
    checks++;
    if (mif.rd_req !== 1'b0) begin errors++; $display("FAIL line239 rd_req: %b, required 0", mif.rd_req); end
    log_addr.delete();
    newline_pulse(8'd19);
    checks += 2;
    if (mif.rd_req !== 1'b1) begin errors++; $display("FAIL row20 start rd_req: %b, required 1", mif.rd_req); end
    if (mif.rd_addr !== 17'd6400) begin errors++; $display("FAIL row20 start addr: %0d, required 6400", mif.rd_addr); end
    wait_acks(100);
    reset = 1'b1;
    @(negedge clk);
    checks += 2;
    if (mif.rd_req !== 1'b0) begin errors++; $display("FAIL midfetch reset rd_req: %b, required 0", mif.rd_req); end
    if (pixel !== 12'd0) begin errors++; $display("FAIL midfetch reset pixel: %0d, required 0", pixel); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks += 2;
    if (mif.rd_req !== 1'b0) begin errors++; $display("FAIL post-reset rd_req: %b, required 0", mif.rd_req); end
    if (log_addr.size() != 100) begin errors++; $display("FAIL post-reset acks: %0d, required 100", log_addr.size()); end
  endtask

  initial begin
    reset       = 1'b1;
    newline     = 1'b0;
    advance     = 1'b0;
    line        = 8'd0;
    mif.rd_ack  = 1'b0;
    mif.rd_data = 12'd0;
    @(negedge clk);
    test_reset();
    test_prefetch();
    test_addressing();
    test_stall();
    test_underrun();
    test_blanking_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
